// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and sizing helper for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    typedef logic [3:0] digit_t;

    // Smallest digit count d such that 10^d > 2^width.
    function automatic int min_digits(input int width);
        longint unsigned pow10;
        longint unsigned limit;
        int              d;
        pow10 = 64'd1;
        limit = 64'd1 << width;
        d     = 0;
        while (pow10 <= limit) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/module_binary_to_bcd_seq_digit_adjust.sv
// rtl/module_binary_to_bcd_seq_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module module_bcd_digit_adjust
    import bcd_pkg::*;
(
    input  digit_t din,
    output digit_t dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/module_binary_to_bcd_seq.sv
// rtl/module_binary_to_bcd_seq.sv - one-bit-per-clock binary-to-BCD converter; BCD_SIGNED_EN enables two's-complement input
module module_binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [WIDTH-1:0]      ENTRADA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  NEG
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
        $error("WIDTH must be in 4..32");
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
        $error("DIGITS too small to hold 2^WIDTH");
    end

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [BW-1:0]     work_q, work_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]     work_adj;
    logic [WIDTH-1:0]  capture_mag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        module_bcd_digit_adjust u_adjust (
            .din  (work_q[4*g +: 4]),
            .dout (work_adj[4*g +: 4])
        );
    end

`ifdef BCD_SIGNED_EN
    // Negating the most negative value wraps to itself, which read unsigned is 2^(WIDTH-1).
    assign capture_mag = ENTRADA[WIDTH-1] ? -ENTRADA : ENTRADA;
`else
    assign capture_mag = ENTRADA;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    op_d    = capture_mag;
                    work_d  = '0;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {work_d, op_d} = {work_adj, op_q} << 1;
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
                if (cnt_q <= CNT_ONE) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                bcd_d   = work_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;

    always_comb begin
        sign_d = sign_q;
        neg_d  = neg_q;
        if (state_q == IDLE && START) begin
            sign_d = ENTRADA[WIDTH-1];
        end
        if (state_q == FINISH) begin
            neg_d = sign_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            neg_q  <= neg_d;
        end
    end

    assign NEG = neg_q;
`else
    assign NEG = 1'b0;
`endif

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = bcd_q;

endmodule

// File: tb/tb_module_binary_to_bcd_seq.sv
// tb/tb_module_binary_to_bcd_seq.sv - directed and exhaustive checks of the sequential BCD converter
module tb_module_binary_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0;
    logic [15:0] ent16 = '0;
    logic        busy16, done16, neg16;
    logic [19:0] bcd16;

    logic        start8 = 1'b0;
    logic [7:0]  ent8 = '0;
    logic        busy8, done8, neg8;
    logic [11:0] bcd8;

    int checks = 0;
    int errors = 0;
    int done8_cnt = 0;

    always #5 clk = ~clk;

    module_binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut16 (
        .CLK(clk), .RST_N(rst_n), .START(start16), .ENTRADA(ent16),
        .BUSY(busy16), .DONE(done16), .BCD(bcd16), .NEG(neg16)
    );

    module_binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .ENTRADA(ent8),
        .BUSY(busy8), .DONE(done8), .BCD(bcd8), .NEG(neg8)
    );

    always @(negedge clk) if (done8 === 1'b1) done8_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd8(input int v);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic conv16(input logic [15:0] v, output int lat);
        @(negedge clk);
        ent16   = v;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        check("busy16_after_start", busy16, 1);
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic conv8(input logic [7:0] v, output int lat);
        @(negedge clk);
        ent8   = v;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        int base;
        int mag;
        logic negx;
        logic [19:0] exp_ffff, exp_8000;
        logic [11:0] exp_ff;
        logic        sgn;

`ifdef BCD_SIGNED_EN
        sgn      = 1'b1;
        exp_ffff = 20'h00001;
        exp_8000 = 20'h32768;
        exp_ff   = 12'h001;
`else
        sgn      = 1'b0;
        exp_ffff = 20'h65535;
        exp_8000 = 20'h32768;
        exp_ff   = 12'h255;
`endif

        repeat (2) @(negedge clk);
        check("reset_bcd", bcd16, 0);
        check("reset_busy", busy16, 0);
        check("reset_done", done16, 0);
        check("reset_neg", neg16, 0);
        rst_n = 1'b1;

        conv16(16'hFFFF, lat);
        check("ffff_latency", lat, 18);
        check("ffff_bcd", bcd16, exp_ffff);
        check("ffff_neg", neg16, sgn);
        check("ffff_busy_low_at_done", busy16, 0);
        @(negedge clk);
        check("done_single_cycle", done16, 0);
        repeat (3) @(negedge clk);
        check("bcd_holds", bcd16, exp_ffff);

        conv16(16'h8000, lat);
        check("8000_bcd", bcd16, exp_8000);
        check("8000_neg", neg16, sgn);

        conv16(16'd300, lat);
        check("300_bcd", bcd16, 20'h00300);
        check("300_neg", neg16, 0);

        conv8(8'hFF, lat);
        check("w8_ff_latency", lat, 10);
        check("w8_ff_bcd", bcd8, exp_ff);
        conv8(8'h00, lat);
        check("w8_zero_done", done8, 1);
        check("w8_zero_bcd", bcd8, 12'h000);

        // START held high: input changes mid-conversion must be ignored
        @(negedge clk);
        ent16   = 16'd1234;
        start16 = 1'b1;
        @(negedge clk);
        ent16 = 16'd42;
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("held_first_latency", lat, 18);
        check("held_first_bcd", bcd16, 20'h01234);
        @(negedge clk);
        start16 = 1'b0;
        check("held_second_busy", busy16, 1);
        lat = 1;
        while (done16 !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("held_second_latency", lat, 18);
        check("held_second_bcd", bcd16, 20'h00042);

        // Abort in the middle of SHIFT
        @(negedge clk);
        ent16   = 16'd500;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_bcd", bcd16, 0);
        check("abort_busy", busy16, 0);
        check("abort_done", done16, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done16 === 1'b1) seen++;
        end
        check("abort_no_done", seen, 0);
        conv16(16'd1000, lat);
        check("after_abort_latency", lat, 18);
        check("after_abort_bcd", bcd16, 20'h01000);

        // Every 8-bit operand against the decimal model
        @(negedge clk);
        base = done8_cnt;
        for (int v = 0; v < 256; v++) begin
            conv8(8'(v), lat);
`ifdef BCD_SIGNED_EN
            negx = (v >= 128);
            mag  = negx ? 256 - v : v;
`else
            negx = 1'b0;
            mag  = v;
`endif
            check("w8_exhaustive_bcd", {ent8, bcd8}, {8'(v), ref_bcd8(mag)});
            check("w8_exhaustive_neg", neg8, negx);
        end
        repeat (2) @(negedge clk);
        check("w8_done_count", done8_cnt - base, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_binary_to_bcd_seq.md
# module_binary_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. One bit is processed per clock, so one adjust stage per digit is reused instead of a full combinational array. It sits between sensor/ADC data paths (PMOD ALS and wider peripherals) and the 7-segment display drivers. A START/DONE handshake lets a controller convert values of any configured width.

## Interface
Parameters:
- WIDTH, 16, binary input width; 4..32.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH (elaboration-time assertion).

Ports:
- CLK, input, 1, single system clock; all logic on rising edge.
- RST_N, input, 1, reset, asynchronous assert, active-low.
- START, input, 1, conversion request; sampled only in IDLE.
- ENTRADA, input, WIDTH, binary operand; captured on the START edge.
- BUSY, input-independent output, 1, high from the capture edge until DONE.
- DONE, output, 1, single-cycle pulse when results update.
- BCD, output, 4*DIGITS, result; digit 0 (units) in [3:0], digit k in [4k+3:4k].
- NEG, output, 1, sign of the last result (present only with the configuration macro; otherwise tied 0).

## Operation
- FSM states are IDLE, SHIFT and FINISH. Reset enters IDLE.
- **IDLE:** when START=1, capture ENTRADA into the shift register, clear the BCD working register, load the bit counter with WIDTH, set BUSY and go to SHIFT.
- **SHIFT:** each cycle:
  - add 3 to every working digit that is >= 5;
  - shift the {BCD working, operand} register left by 1;
  - decrement the counter.
  - After the WIDTH-th shift, go to FINISH.
- **FINISH:** copy the working register to BCD (and the sign to NEG), pulse DONE, clear BUSY, and return to IDLE.
- START outside IDLE is ignored. It is not queued.
- BCD and NEG hold their values until the next FINISH.
- Working digits never exceed 9 after a shift, and the adjust is 4-bit wraparound-free. Upper digits beyond the value's magnitude read 0.

## Timing
- Reset values:
  - BCD = 0, NEG = 0, DONE = 0, BUSY = 0, state = IDLE;
  - counter and working registers = 0.
- START sampled high at edge t sets BUSY=1 after edge t.
- SHIFT occupies edges t+1 .. t+WIDTH, and FINISH is at edge t+WIDTH+1.
- Latency: BCD valid and DONE=1 in the cycle after edge t+WIDTH+1. DONE is low one cycle later.
- BUSY falls together with the DONE assertion.
- Throughput: a new START is accepted in the cycle after DONE at the earliest, which gives one conversion per WIDTH+2 cycles.
- RST_N low mid-conversion aborts immediately. All outputs return to reset values, and no DONE pulse is issued.
- The maximum operand 2^WIDTH−1 converts correctly. The counter saturates at 0 and does not wrap.

## Configuration
- **BCD_SIGNED_EN defined:** ENTRADA is two's complement.
  - At capture, the magnitude (−x for negative x) is loaded and the sign is registered.
  - NEG reflects the sign at FINISH.
  - The most negative value −2^(WIDTH−1) converts to magnitude 2^(WIDTH−1) with NEG=1.
- **Not defined:** ENTRADA is unsigned, NEG is constant 0, and no sign or negation logic is synthesized.

## Structure
- Package bcd_pkg holds:
  - the FSM state typedef (IDLE, SHIFT, FINISH);
  - the BCD digit typedef (logic [3:0]);
  - a constant function returning the minimum DIGITS for a given WIDTH, used by the assertion.
- Sub-module module_bcd_digit_adjust: 4-bit in, 4-bit out, add 3 when the input is >= 5. It is instantiated DIGITS times via generate.

## Test plan
- WIDTH=16, DIGITS=5, ENTRADA=65535, START pulse: DONE at cycle 18 after START, BCD digits 6,5,5,3,5 (0x65535).
- WIDTH=8, DIGITS=3, ENTRADA=255: BCD=0x255 after 10 cycles. ENTRADA=0: BCD=0x000 and DONE still pulses.
- Hold START high continuously with ENTRADA changing during SHIFT: only the value captured at the first edge is converted. The next capture happens the cycle after DONE, giving back-to-back 1234 then 42 results.
- Assert RST_N low at SHIFT cycle 5: BCD=0, BUSY=0, and no DONE. A following START with ENTRADA=1000 yields 0x01000.
- With BCD_SIGNED_EN, WIDTH=16:
  - ENTRADA=−32768: NEG=1, BCD=0x32768;
  - ENTRADA=−1: NEG=1, BCD=0x00001;
  - ENTRADA=300: NEG=0, BCD=0x00300.
- Exhaustive check for WIDTH=8: all 256 inputs against a reference model, with DONE count = 256.
